// File: rtl/xbar_host_arb.sv
// Two-host TL-UL arbiter: merges instruction-fetch and load-store requests onto one
// crossbar port and routes in-order responses back through a host-id FIFO.
package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module xbar_host_arb #(
    parameter int unsigned Depth = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_if_i,
    output tlul_pkg::tl_d2h_t tl_if_o,
    input  tlul_pkg::tl_h2d_t tl_lsu_i,
    output tlul_pkg::tl_d2h_t tl_lsu_o,
    output tlul_pkg::tl_h2d_t tl_dev_o,
    input  tlul_pkg::tl_d2h_t tl_dev_i,
    output logic [3:0]        outstanding_o,
    output logic              err_unexpected_o
);
    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [3:0]      DepthC  = 4'(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    // r_run stays low through reset and its first clock so no host sees a handshake then
    logic             r_run;
    logic             r_ptr;
    logic             r_lock;
    logic             r_lock_host;
    logic [3:0]       r_count;
    logic [PtrW-1:0]  r_wr;
    logic [PtrW-1:0]  r_rd;
    logic [Depth-1:0] r_fifo;

    logic              w_full;
    logic              w_empty;
    logic              w_gnt;
    logic              w_a_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_head;
    logic              w_d_ready;
    tlul_pkg::tl_h2d_t w_gnt_req;

    // Grant selection, FIFO handshakes and per-host channel steering
    always_comb begin
        w_full  = (r_count == DepthC);
        w_empty = (r_count == 4'd0);
        if (r_lock) begin
            w_gnt = r_lock_host;
        end else if (tl_if_i.a_valid && tl_lsu_i.a_valid) begin
            w_gnt = r_ptr;
        end else if (tl_lsu_i.a_valid) begin
            w_gnt = 1'b1;
        end else begin
            w_gnt = 1'b0;
        end
        w_gnt_req = w_gnt ? tl_lsu_i : tl_if_i;
        w_a_valid = r_run && !w_full && w_gnt_req.a_valid;
        w_push    = w_a_valid && tl_dev_i.a_ready;
        w_head    = r_fifo[r_rd];
        // A beat with nothing outstanding is swallowed so the crossbar never stalls on it
        if (w_empty) begin
            w_d_ready = 1'b1;
        end else begin
            w_d_ready = w_head ? tl_lsu_i.d_ready : tl_if_i.d_ready;
        end
        w_pop = !w_empty && tl_dev_i.d_valid && w_d_ready;

        tl_dev_o         = w_gnt_req;
        tl_dev_o.a_valid = w_a_valid;
        tl_dev_o.d_ready = w_d_ready;

        tl_if_o          = tl_dev_i;
        tl_if_o.a_ready  = r_run && !w_full && !w_gnt && tl_dev_i.a_ready;
        tl_if_o.d_valid  = !w_empty && !w_head && tl_dev_i.d_valid;

        tl_lsu_o         = tl_dev_i;
        tl_lsu_o.a_ready = r_run && !w_full && w_gnt && tl_dev_i.a_ready;
        tl_lsu_o.d_valid = !w_empty && w_head && tl_dev_i.d_valid;

        err_unexpected_o = r_run && w_empty && tl_dev_i.d_valid;
    end

    // Arbitration state, host-id FIFO and occupancy count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run       <= 1'b0;
            r_ptr       <= 1'b0;
            r_lock      <= 1'b0;
            r_lock_host <= 1'b0;
            r_count     <= 4'd0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_fifo      <= '0;
        end else begin
            r_run       <= 1'b1;
            r_lock      <= w_a_valid && !tl_dev_i.a_ready;
            r_lock_host <= w_gnt;
            if (w_push) begin
                r_fifo[r_wr] <= w_gnt;
                r_wr         <= (r_wr == LastPtr) ? '0 : r_wr + PtrW'(1);
                r_ptr        <= ~r_ptr;
            end
            if (w_pop) begin
                r_rd <= (r_rd == LastPtr) ? '0 : r_rd + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    assign outstanding_o = r_count;
endmodule

// File: tb/tb_xbar_host_arb.sv
// Bench for xbar_host_arb: directed scenarios plus randomized traffic checked
// against a queue-based model of the arbitration and response-routing rules.
module tb_xbar_host_arb;
    import tlul_pkg::*;

    localparam int Depth = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    tl_h2d_t    tl_if_i, tl_lsu_i, tl_dev_o;
    tl_d2h_t    tl_if_o, tl_lsu_o, tl_dev_i;
    logic [3:0] outstanding_o;
    logic       err_unexpected_o;
    int         checks = 0;
    int         errors = 0;

    always #5 clk_i = ~clk_i;

    xbar_host_arb #(.Depth(Depth)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .tl_if_i(tl_if_i), .tl_if_o(tl_if_o),
        .tl_lsu_i(tl_lsu_i), .tl_lsu_o(tl_lsu_o),
        .tl_dev_o(tl_dev_o), .tl_dev_i(tl_dev_i),
        .outstanding_o(outstanding_o), .err_unexpected_o(err_unexpected_o)
    );

    function automatic tl_h2d_t mk_req(input logic [7:0] src);
        tl_h2d_t r;
        r           = '0;
        r.a_valid   = 1'b1;
        r.a_opcode  = 3'($urandom_range(0, 4));
        r.a_size    = 2'd2;
        r.a_source  = src;
        r.a_address = $urandom;
        r.a_mask    = 4'hF;
        r.a_data    = $urandom;
        return r;
    endfunction

    task automatic clear_inputs();
        tl_if_i  = '0;
        tl_lsu_i = '0;
        tl_dev_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni   = 1'b0;
        tl_if_i  = mk_req(8'h11);
        tl_lsu_i = mk_req(8'h22);
        tl_dev_i = '0;
        tl_dev_i.a_ready = 1'b1;
        tl_dev_i.d_valid = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.a_valid, tl_if_o.a_ready, tl_lsu_o.a_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_a_side got %b want 000", {tl_dev_o.a_valid, tl_if_o.a_ready, tl_lsu_o.a_ready});
        end
        checks++;
        if ({tl_if_o.d_valid, tl_lsu_o.d_valid, err_unexpected_o, outstanding_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_d_side got %b want 0000000", {tl_if_o.d_valid, tl_lsu_o.d_valid, err_unexpected_o, outstanding_o});
        end
        do_reset();
    endtask

    task automatic test_both_valid();
        do_reset();
        tl_if_i  = mk_req(8'h11);
        tl_lsu_i = mk_req(8'h22);
        tl_dev_i.a_ready = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.a_valid, tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready} !== {1'b1, 8'h11, 2'b10}) begin
            errors++;
            $display("FAIL both_cycle1 got %h want %h", {tl_dev_o.a_valid, tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready}, {1'b1, 8'h11, 2'b10});
        end
        checks++;
        if (tl_dev_o.a_address !== tl_if_i.a_address) begin
            errors++;
            $display("FAIL both_addr got %h want %h", tl_dev_o.a_address, tl_if_i.a_address);
        end
        @(posedge clk_i); #1;
        tl_if_i = mk_req(8'h13);
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.a_valid, tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready} !== {1'b1, 8'h22, 2'b01}) begin
            errors++;
            $display("FAIL both_cycle2 got %h want %h", {tl_dev_o.a_valid, tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready}, {1'b1, 8'h22, 2'b01});
        end
        @(posedge clk_i); #1;
        clear_inputs();
        @(negedge clk_i);
        checks++;
        if (outstanding_o !== 4'd2) begin
            errors++;
            $display("FAIL both_outstanding got %0d want 2", outstanding_o);
        end
    endtask

    task automatic test_lock();
        logic [10:0] exp_v [5];
        exp_v = '{ {1'b1, 8'h22, 2'b00}, {1'b1, 8'h22, 2'b00}, {1'b1, 8'h22, 2'b00},
                   {1'b1, 8'h22, 2'b00}, {1'b1, 8'h22, 2'b01} };
        do_reset();
        tl_lsu_i = mk_req(8'h22);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) tl_if_i = mk_req(8'h11);
            tl_dev_i.a_ready = (i == 4);
            @(negedge clk_i);
            checks++;
            if ({tl_dev_o.a_valid, tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready} !== exp_v[i]) begin
                errors++;
                $display("FAIL lock_cycle%0d got %h want %h", i, {tl_dev_o.a_valid, tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready}, exp_v[i]);
            end
            @(posedge clk_i); #1;
        end
        tl_lsu_i = '0;
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.a_valid, tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready} !== {1'b1, 8'h11, 2'b10}) begin
            errors++;
            $display("FAIL lock_release got %h want %h", {tl_dev_o.a_valid, tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready}, {1'b1, 8'h11, 2'b10});
        end
        @(posedge clk_i); #1;
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        tl_if_i = mk_req(8'h11);
        tl_dev_i.a_ready = 1'b1;
        for (int i = 0; i < Depth; i++) begin
            @(negedge clk_i);
            checks++;
            if (tl_if_o.a_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill%0d a_ready got %b want 1", i, tl_if_o.a_ready);
            end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.a_valid, tl_if_o.a_ready, outstanding_o} !== {2'b00, 4'd4}) begin
            errors++;
            $display("FAIL full_block got %b want 000100", {tl_dev_o.a_valid, tl_if_o.a_ready, outstanding_o});
        end
        @(posedge clk_i); #1;
        tl_dev_i.d_valid = 1'b1;
        tl_if_i.d_ready  = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.a_valid, tl_if_o.a_ready, tl_if_o.d_valid, tl_dev_o.d_ready, outstanding_o} !== {4'b0011, 4'd4}) begin
            errors++;
            $display("FAIL full_pop_blocks got %b want 00110100", {tl_dev_o.a_valid, tl_if_o.a_ready, tl_if_o.d_valid, tl_dev_o.d_ready, outstanding_o});
        end
        @(posedge clk_i); #1;
        tl_dev_i.d_valid = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.a_valid, tl_if_o.a_ready, outstanding_o} !== {2'b11, 4'd3}) begin
            errors++;
            $display("FAIL full_reopen got %b want 110011", {tl_dev_o.a_valid, tl_if_o.a_ready, outstanding_o});
        end
        @(posedge clk_i); #1;
        clear_inputs();
        @(negedge clk_i);
        checks++;
        if (outstanding_o !== 4'd4) begin
            errors++;
            $display("FAIL full_refill got %0d want 4", outstanding_o);
        end
    endtask

    task automatic test_order();
        logic [7:0] exp_src [3];
        logic [31:0] got_data;
        exp_src = '{8'h11, 8'h22, 8'h11};
        do_reset();
        tl_if_i  = mk_req(8'h11);
        tl_lsu_i = mk_req(8'h22);
        tl_dev_i.a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (tl_dev_o.a_source !== exp_src[i]) begin
                errors++;
                $display("FAIL order_grant%0d got %h want %h", i, tl_dev_o.a_source, exp_src[i]);
            end
            @(posedge clk_i); #1;
        end
        clear_inputs();
        tl_if_i.d_ready  = 1'b1;
        tl_lsu_i.d_ready = 1'b1;
        tl_dev_i.d_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tl_dev_i.d_data = 32'hD000_0000 + 32'(i);
            @(negedge clk_i);
            checks++;
            if ({tl_if_o.d_valid, tl_lsu_o.d_valid} !== ((i == 1) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL order_route%0d got %b want %b", i, {tl_if_o.d_valid, tl_lsu_o.d_valid}, (i == 1) ? 2'b01 : 2'b10);
            end
            got_data = (i == 1) ? tl_lsu_o.d_data : tl_if_o.d_data;
            checks++;
            if (got_data !== 32'hD000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL order_data%0d got %h want %h", i, got_data, 32'hD000_0000 + 32'(i));
            end
            @(posedge clk_i); #1;
        end
        clear_inputs();
        @(negedge clk_i);
        checks++;
        if (outstanding_o !== 4'd0) begin
            errors++;
            $display("FAIL order_drained got %0d want 0", outstanding_o);
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        tl_dev_i.d_valid = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.d_ready, err_unexpected_o, tl_if_o.d_valid, tl_lsu_o.d_valid, outstanding_o} !== {4'b1100, 4'd0}) begin
            errors++;
            $display("FAIL unexp_beat got %b want 11000000", {tl_dev_o.d_ready, err_unexpected_o, tl_if_o.d_valid, tl_lsu_o.d_valid, outstanding_o});
        end
        @(posedge clk_i); #1;
        tl_dev_i.d_valid = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({err_unexpected_o, outstanding_o} !== 5'b0) begin
            errors++;
            $display("FAIL unexp_after got %b want 00000", {err_unexpected_o, outstanding_o});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tl_if_i = mk_req(8'h11);
        tl_dev_i.a_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 clear_inputs();
        @(negedge clk_i);
        checks++;
        if (outstanding_o !== 4'd3) begin
            errors++;
            $display("FAIL mid_before got %0d want 3", outstanding_o);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({outstanding_o, err_unexpected_o, tl_dev_o.a_valid} !== 6'b0) begin
            errors++;
            $display("FAIL mid_async_clear got %b want 000000", {outstanding_o, err_unexpected_o, tl_dev_o.a_valid});
        end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        tl_if_i  = mk_req(8'h11);
        tl_lsu_i = mk_req(8'h22);
        tl_dev_i.a_ready = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready} !== {8'h11, 2'b10}) begin
            errors++;
            $display("FAIL mid_ptr_reset got %h want %h", {tl_dev_o.a_source, tl_if_o.a_ready, tl_lsu_o.a_ready}, {8'h11, 2'b10});
        end
        @(posedge clk_i); #1;
        clear_inputs();
    endtask

    task automatic test_random();
        int      q[$];
        bit      ptr, lk, lk_h, full, empty, av, exp_dr, push, pop;
        int      g;
        tl_h2d_t req [2];
        do_reset();
        ptr = 1'b0; lk = 1'b0; lk_h = 1'b0;
        req[0] = '0; req[1] = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int h = 0; h < 2; h++) begin
                if (!req[h].a_valid && $urandom_range(0, 2) == 0) req[h] = mk_req(8'(h * 128 + cyc % 128));
                req[h].d_ready = 1'($urandom_range(0, 1));
            end
            tl_if_i  = req[0];
            tl_lsu_i = req[1];
            tl_dev_i = '0;
            tl_dev_i.a_ready  = ($urandom_range(0, 3) != 0);
            tl_dev_i.d_data   = $urandom;
            tl_dev_i.d_source = 8'($urandom);
            tl_dev_i.d_valid  = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            @(negedge clk_i);
            full  = (q.size() == Depth);
            empty = (q.size() == 0);
            if (lk) g = int'(lk_h);
            else if (req[0].a_valid && req[1].a_valid) g = int'(ptr);
            else g = int'(req[1].a_valid);
            av = !full && req[g].a_valid;
            exp_dr = empty ? 1'b1 : req[q[0]].d_ready;
            checks++;
            if (tl_dev_o.a_valid !== av) begin
                errors++;
                $display("FAIL rnd_a_valid cyc %0d got %b want %b", cyc, tl_dev_o.a_valid, av);
            end
            if (av) begin
                checks++;
                if ({tl_dev_o.a_source, tl_dev_o.a_address} !== {req[g].a_source, req[g].a_address}) begin
                    errors++;
                    $display("FAIL rnd_a_fields cyc %0d got %h want %h", cyc, {tl_dev_o.a_source, tl_dev_o.a_address}, {req[g].a_source, req[g].a_address});
                end
            end
            for (int h = 0; h < 2; h++) begin
                if (req[h].a_valid || h != g) begin
                    checks++;
                    if (((h == 0) ? tl_if_o.a_ready : tl_lsu_o.a_ready) !== ((h == g) && !full && tl_dev_i.a_ready)) begin
                        errors++;
                        $display("FAIL rnd_a_ready%0d cyc %0d got %b want %b", h, cyc, (h == 0) ? tl_if_o.a_ready : tl_lsu_o.a_ready, (h == g) && !full && tl_dev_i.a_ready);
                    end
                end
                checks++;
                if (((h == 0) ? tl_if_o.d_valid : tl_lsu_o.d_valid) !== (!empty && q[0] == h && tl_dev_i.d_valid)) begin
                    errors++;
                    $display("FAIL rnd_d_valid%0d cyc %0d got %b want %b", h, cyc, (h == 0) ? tl_if_o.d_valid : tl_lsu_o.d_valid, !empty && q[0] == h && tl_dev_i.d_valid);
                end
            end
            checks++;
            if ({tl_dev_o.d_ready, err_unexpected_o, outstanding_o} !== {exp_dr, empty && tl_dev_i.d_valid, 4'(q.size())}) begin
                errors++;
                $display("FAIL rnd_d_side cyc %0d got %b want %b", cyc, {tl_dev_o.d_ready, err_unexpected_o, outstanding_o}, {exp_dr, empty && tl_dev_i.d_valid, 4'(q.size())});
            end
            push = av && tl_dev_i.a_ready;
            pop  = !empty && tl_dev_i.d_valid && exp_dr;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(g);
                ptr = !ptr;
                req[g] = '0;
            end
            lk   = av && !tl_dev_i.a_ready;
            lk_h = 1'(g);
            @(posedge clk_i); #1;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_both_valid();
        test_lock();
        test_full();
        test_order();
        test_unexpected();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/xbar_host_arb.md
XBAR_HOST_ARB -- requirements
Module: xbar_host_arb

Interface
REQ-001 SHALL have parameter Depth, default 4, giving the maximum number of outstanding accepted requests (range 1..15).
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port tl_if_i, input, tlul_pkg::tl_h2d_t, the instruction-fetch host request (host 0).
REQ-005 SHALL have port tl_if_o, output, tlul_pkg::tl_d2h_t, the instruction-fetch host response.
REQ-006 SHALL have port tl_lsu_i, input, tlul_pkg::tl_h2d_t, the load-store host request (host 1).
REQ-007 SHALL have port tl_lsu_o, output, tlul_pkg::tl_d2h_t, the load-store host response.
REQ-008 SHALL have port tl_dev_o, output, tlul_pkg::tl_h2d_t, the merged request to the peripheral crossbar host port.
REQ-009 SHALL have port tl_dev_i, input, tlul_pkg::tl_d2h_t, the crossbar response.
REQ-010 SHALL have port outstanding_o, output, 4, the current count of accepted requests not yet answered.
REQ-011 SHALL have port err_unexpected_o, output, 1, a one-cycle pulse on a response received with no outstanding request.

Function
REQ-012 SHALL forward the granted host's A-channel fields to tl_dev_o unmodified, including a_source; all other fields SHALL be driven from the granted host only.
REQ-013 SHALL drive tl_dev_o.a_valid=0 when neither host is valid, or when the count equals Depth.
REQ-014 SHALL block new requests while the count equals Depth, even if a pop occurs in the same cycle.
REQ-015 SHALL grant a lone valid host combinationally in the same cycle, with no added latency.
REQ-016 SHALL grant the host indicated by a priority pointer when both hosts are valid; the pointer resets to host 0 (IF).
REQ-017 SHALL flip the pointer to the other host on each accepted A handshake (tl_dev_o.a_valid && tl_dev_i.a_ready).
REQ-018 SHALL hold the grant when tl_dev_o.a_valid is asserted and a_ready is 0, via a lock register, until the handshake completes, regardless of the other host.
REQ-019 SHALL drive a_ready=tl_dev_i.a_ready to the granted host only; the non-granted host SHALL see a_ready=0.
REQ-020 SHALL push the granted host id (0/1) into an in-order FIFO of Depth entries on each accepted A handshake.
REQ-021 SHALL route D-channel responses, which return in request order, to the host at the FIFO head.
REQ-022 SHALL drive d_valid and all D fields from tl_dev_i to the head host; the other host SHALL see d_valid=0.
REQ-023 SHALL drive tl_dev_o.d_ready from the head host's d_ready.
REQ-024 SHALL pop the FIFO on tl_dev_i.d_valid && tl_dev_o.d_ready.
REQ-025 SHALL update the count on simultaneous push and pop as count+1-1=unchanged, with the pointer-based FIFO writing and reading different entries correctly; at count==0, push and pop cannot coincide.
REQ-026 SHALL, when the FIFO is empty and tl_dev_i.d_valid=1, force tl_dev_o.d_ready=1, drop the beat, deliver d_valid=0 to both hosts and pulse err_unexpected_o high for one cycle per beat.
REQ-027 SHALL drive outstanding_o from a registered count equal to FIFO occupancy; the count never exceeds Depth or underflows.

Reset
REQ-028 SHALL, on rst_ni low (asynchronous), clear the FIFO, count=0, lock=0 and pointer=host 0.
REQ-029 SHALL, during and after reset, drive outputs as follows: tl_dev_o.a_valid=0, both host a_ready=0 and d_valid=0, outstanding_o=0, err_unexpected_o=0.
REQ-030 SHALL discard requests in flight at reset mid-operation without error pulses; late responses after reset are handled per REQ-026.

Verification
REQ-031 SHALL cover: both hosts valid in cycle 1 with a_ready=1 -> IF granted cycle 1, LSU cycle 2, outstanding_o=2.
REQ-032 SHALL cover: LSU valid and a_ready=0 for 3 cycles, then IF valid -> grant stays on LSU until the handshake; IF a_ready=0 throughout.
REQ-033 SHALL cover: Depth=4 with 4 requests accepted and no responses -> a 5th request sees a_valid=0 and a_ready=0; a response plus pop in the same cycle still blocks; the next cycle accepts.
REQ-034 SHALL cover: IF, LSU, IF accepted, then 3 responses -> routed to IF, LSU, IF in order, with the non-head host seeing d_valid=0.
REQ-035 SHALL cover: d_valid with outstanding_o=0 -> d_ready=1, err_unexpected_o=1 for exactly 1 cycle, no host d_valid.
REQ-036 SHALL cover: rst_ni low mid-transaction with outstanding_o=3 -> outstanding_o=0 immediately, pointer back to IF.
